// File: rtl/watch_cmd_decoder_if.sv
// UART-side command inputs and watch-side adjust outputs of watch_cmd_decoder.
// Build macro CMD_ECHO_EN adds the echo transmit signals.
interface watch_cmd_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       d_sec_add;
  logic       d_min_add;
  logic       d_hour_add;
  logic       watch_mod_sw;
  logic       cmd_err;
`ifdef CMD_ECHO_EN
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  modport master (
    output rx_data, rx_done, tx_busy,
    input  d_sec_add, d_min_add, d_hour_add, watch_mod_sw, cmd_err, tx_data, tx_start
  );
  modport slave (
    input  rx_data, rx_done, tx_busy,
    output d_sec_add, d_min_add, d_hour_add, watch_mod_sw, cmd_err, tx_data, tx_start
  );
`else
  modport master (
    output rx_data, rx_done,
    input  d_sec_add, d_min_add, d_hour_add, watch_mod_sw, cmd_err
  );
  modport slave (
    input  rx_data, rx_done,
    output d_sec_add, d_min_add, d_hour_add, watch_mod_sw, cmd_err
  );
`endif
endinterface

// File: rtl/watch_cmd_decoder.sv
// Decodes UART command bytes into timed watch adjust pulses with a 1-deep queue.
// Build macro CMD_ECHO_EN enables echoing of accepted bytes on tx_data/tx_start.
module watch_cmd_decoder #(
  parameter int unsigned PULSE_CYC = 10,
  parameter int unsigned GAP_CYC   = 2
) (
  input logic               clk,
  input logic               reset,
  watch_cmd_decoder_if.slave bus
);
  localparam int unsigned MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_SEC, CMD_MIN, CMD_HOUR} cmd_t;

  state_t        state_q, state_n;
  cmd_t          cur_q, cur_n, pend_cmd_q, pend_cmd_n, adj_cmd;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          pend_valid_q, pend_valid_n;
  logic          mod_q, mod_n;
  logic          err_q, err_n;
  logic          sec_q, min_q, hour_q;
  logic          is_tog, is_ign, is_adj, accept, pend_consume;
  logic [7:0]    folded;

  // Setting bit 5 folds upper-case letters onto lower-case; control bytes never alias a command.
  assign folded = bus.rx_data | 8'h20;

  always_comb begin
    adj_cmd = CMD_NONE;
    is_tog  = 1'b0;
    is_ign  = 1'b0;
    if (bus.rx_data == 8'h0D || bus.rx_data == 8'h0A) begin
      is_ign = 1'b1;
    end else begin
      case (folded)
        8'h73:   adj_cmd = CMD_SEC;
        8'h6D:   adj_cmd = CMD_MIN;
        8'h68:   adj_cmd = CMD_HOUR;
        8'h77:   is_tog  = 1'b1;
        default: ;
      endcase
    end
  end

  assign is_adj = (adj_cmd != CMD_NONE);

  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q + CW'(1);
    cur_n        = cur_q;
    pend_valid_n = pend_valid_q;
    pend_cmd_n   = pend_cmd_q;
    mod_n        = mod_q;
    err_n        = 1'b0;
    accept       = 1'b0;
    pend_consume = 1'b0;

    if (bus.rx_done && is_tog) begin
      mod_n  = ~mod_q;
      accept = 1'b1;
    end

    case (state_q)
      IDLE: cnt_n = '0;
      HOLD: begin
        if (!mod_q) begin
          state_n      = GAP;
          cnt_n        = '0;
          pend_valid_n = 1'b0;
        end else if (cnt_q == PULSE_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_n        = '0;
          pend_valid_n = 1'b0;
          if (pend_valid_q && mod_q) begin
            state_n      = HOLD;
            cur_n        = pend_cmd_q;
            pend_consume = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Keyed on state_n so a byte landing on the last GAP cycle starts or queues instead of being lost.
    if (bus.rx_done && is_adj) begin
      if (!mod_q) begin
        err_n = 1'b1;
      end else if (state_n == IDLE) begin
        state_n = HOLD;
        cnt_n   = '0;
        cur_n   = adj_cmd;
        accept  = 1'b1;
      end else if (!pend_valid_q || pend_consume) begin
        pend_valid_n = 1'b1;
        pend_cmd_n   = adj_cmd;
        accept       = 1'b1;
      end else begin
        err_n = 1'b1;
      end
    end

    if (bus.rx_done && !is_adj && !is_tog && !is_ign) err_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_q        <= CMD_NONE;
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= CMD_NONE;
      mod_q        <= 1'b0;
      err_q        <= 1'b0;
      sec_q        <= 1'b0;
      min_q        <= 1'b0;
      hour_q       <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      cur_q        <= cur_n;
      pend_valid_q <= pend_valid_n;
      pend_cmd_q   <= pend_cmd_n;
      mod_q        <= mod_n;
      err_q        <= err_n;
      sec_q        <= (state_n == HOLD) && (cur_n == CMD_SEC);
      min_q        <= (state_n == HOLD) && (cur_n == CMD_MIN);
      hour_q       <= (state_n == HOLD) && (cur_n == CMD_HOUR);
    end
  end

  assign bus.d_sec_add    = sec_q;
  assign bus.d_min_add    = min_q;
  assign bus.d_hour_add   = hour_q;
  assign bus.watch_mod_sw = mod_q;
  assign bus.cmd_err      = err_q;

`ifdef CMD_ECHO_EN
  logic       echo_valid;
  logic [7:0] echo_byte;
  logic [7:0] tx_data_q;
  logic       tx_start_q;

  // A buffered echo goes out first; a byte accepted in that same cycle takes its buffer slot.
  always_ff @(posedge clk) begin
    if (!reset) begin
      echo_valid <= 1'b0;
      echo_byte  <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      if (echo_valid && !bus.tx_busy) begin
        tx_data_q  <= echo_byte;
        tx_start_q <= 1'b1;
        echo_valid <= accept;
        if (accept) echo_byte <= bus.rx_data;
      end else if (accept && !echo_valid) begin
        if (!bus.tx_busy) begin
          tx_data_q  <= bus.rx_data;
          tx_start_q <= 1'b1;
        end else begin
          echo_valid <= 1'b1;
          echo_byte  <= bus.rx_data;
        end
      end
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
`endif

endmodule
